counter_cmd_ctrl: RTL and testbench

- Front-end command stage that sits directly upstream of the 4-bit load/up/down counter.
- Takes three raw, asynchronous push-button inputs and synchronises and debounces each one.
- Converts presses into single-cycle, mutually exclusive load/up/down command pulses.
- Adds auto-repeat while the up or down button is held.

---
 rtl/counter_cmd_ctrl_if.sv | 21 ++
 rtl/counter_cmd_ctrl.sv | 157 +++++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/counter_cmd_ctrl_if.sv
// Button/command bundle between the push-button front end and its user:
// raw buttons in, one-cycle counter commands and repeat status out.
interface counter_cmd_ctrl_if;
    logic btn_load;
    logic btn_up;
    logic btn_down;
    logic load;
    logic up;
    logic down;
    logic repeating;

    modport master (
        output btn_load, btn_up, btn_down,
        input  load, up, down, repeating
    );

    modport slave (
        input  btn_load, btn_up, btn_down,
        output load, up, down, repeating
    );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// Push-button command front end: synchronise and debounce three buttons, then
// issue mutually exclusive one-cycle load/up/down pulses with up/down auto-repeat.
module counter_cmd_ctrl #(
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic              clk,
    input  logic              reset,
    counter_cmd_ctrl_if.slave cmd
);
    localparam int DB_W    = $clog2(DB_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    localparam int B_LOAD = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DELAY    = 2'd1;
    localparam logic [1:0] S_REPEAT   = 2'd2;
    localparam logic [1:0] S_WAIT_REL = 2'd3;

    logic [2:0]           btn_raw;
    logic [2:0]           sync_p0;
    logic [2:0]           sync_p1;
    logic [2:0]           db_p2;
    logic [2:0][DB_W-1:0] db_cnt_p2;
    logic [2:0]           db_prev_p3;
    logic [2:0]           rise_p3;

    logic [1:0]       state_p3, state_nxt;
    logic             owner_down_p3, owner_down_nxt;
    logic [RPT_W-1:0] rpt_cnt_p3, rpt_cnt_nxt;
    logic             load_p3, load_nxt;
    logic             up_p3, up_nxt;
    logic             down_p3, down_nxt;
    logic             rep_p3;
    logic             owner_lvl, other_lvl;

    assign btn_raw = {cmd.btn_down, cmd.btn_up, cmd.btn_load};

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounced level flips after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_p2     <= '0;
            db_cnt_p2 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    db_cnt_p2[i] <= '0;
                end else if (db_cnt_p2[i] == DB_LAST) begin
                    db_p2[i]     <= sync_p1[i];
                    db_cnt_p2[i] <= '0;
                end else begin
                    db_cnt_p2[i] <= db_cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: edge detection, command FSM and registered outputs
    assign rise_p3   = db_p2 & ~db_prev_p3;
    assign owner_lvl = owner_down_p3 ? db_p2[B_DOWN] : db_p2[B_UP];
    assign other_lvl = owner_down_p3 ? db_p2[B_UP]   : db_p2[B_DOWN];

    always_comb begin
        state_nxt      = state_p3;
        owner_down_nxt = owner_down_p3;
        rpt_cnt_nxt    = rpt_cnt_p3;
        load_nxt       = 1'b0;
        up_nxt         = 1'b0;
        down_nxt       = 1'b0;
        case (state_p3)
            S_IDLE: begin
                if (rise_p3[B_LOAD]) begin
                    load_nxt  = 1'b1;
                    state_nxt = S_WAIT_REL;
                end else if (rise_p3[B_UP] || rise_p3[B_DOWN]) begin
                    if (db_p2[B_UP] && db_p2[B_DOWN]) begin
                        state_nxt = S_WAIT_REL;
                    end else begin
                        owner_down_nxt = !rise_p3[B_UP];
                        up_nxt         = rise_p3[B_UP];
                        down_nxt       = !rise_p3[B_UP];
                        rpt_cnt_nxt    = DELAY_LAST;
                        state_nxt      = S_DELAY;
                    end
                end
            end
            S_DELAY, S_REPEAT: begin
                // A fresh load press wins over a repeat pulse due in the same cycle
                if (rise_p3[B_LOAD]) begin
                    load_nxt  = 1'b1;
                    state_nxt = S_WAIT_REL;
                end else if (!owner_lvl) begin
                    state_nxt = S_IDLE;
                end else if (other_lvl) begin
                    state_nxt = S_WAIT_REL;
                end else if (rpt_cnt_p3 == '0) begin
                    up_nxt      = !owner_down_p3;
                    down_nxt    = owner_down_p3;
                    rpt_cnt_nxt = RATE_LAST;
                    state_nxt   = S_REPEAT;
                end else begin
                    rpt_cnt_nxt = rpt_cnt_p3 - 1'b1;
                end
            end
            default: begin
                if (db_p2 == 3'b000) state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_prev_p3    <= '0;
            state_p3      <= S_IDLE;
            owner_down_p3 <= 1'b0;
            rpt_cnt_p3    <= '0;
            load_p3       <= 1'b0;
            up_p3         <= 1'b0;
            down_p3       <= 1'b0;
            rep_p3        <= 1'b0;
        end else begin
            db_prev_p3    <= db_p2;
            state_p3      <= state_nxt;
            owner_down_p3 <= owner_down_nxt;
            rpt_cnt_p3    <= rpt_cnt_nxt;
            load_p3       <= load_nxt;
            up_p3         <= up_nxt;
            down_p3       <= down_nxt;
            rep_p3        <= (state_nxt == S_REPEAT);
        end
    end

    assign cmd.load      = load_p3;
    assign cmd.up        = up_p3;
    assign cmd.down      = down_p3;
    assign cmd.repeating = rep_p3;
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl: per-cycle vector table for single presses
// and glitches, plus hand-built sequences for repeat, conflict, override and reset.
module tb_counter_cmd_ctrl;
    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [3:0] o;
    logic [3:0] exp_o;

    counter_cmd_ctrl_if bus ();

    counter_cmd_ctrl #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // One record per clock: raw buttons driven, then {load,up,down,repeating} expected after the edge
    typedef struct packed {
        logic       bl;
        logic       bu;
        logic       bd;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    int ups_auto[$]  = '{6, 14, 18, 22, 26, 30, 34, 38, 42};
    int ups_conf[$]  = '{6, 14, 18, 22};
    int downs_ovr[$] = '{6, 14, 18, 22};
    int ups_rst[$]   = '{6, 14, 18, 22, 26, 30};

    function automatic logic [3:0] outs();
        return {bus.load, bus.up, bus.down, bus.repeating};
    endfunction

    function automatic bit has(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add(input logic bl, input logic bu, input logic bd, input logic [3:0] e);
        vec_t v;
        v.bl  = bl;
        v.bu  = bu;
        v.bd  = bd;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int c, input logic [3:0] act, input logic [3:0] e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: {load,up,down,rep} got %b expected %b", name, c, act, e);
        end
    endtask

    task automatic cyc(input logic bl, input logic bu, input logic bd, output logic [3:0] r);
        bus.btn_load = bl;
        bus.btn_up   = bu;
        bus.btn_down = bd;
        @(posedge clk);
        #1;
        r = outs();
    endtask

    initial begin
        bus.btn_load = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2 check("reset_held", 0, outs(), 4'b0000);
        #1 reset = 1'b1;
        #1 check("reset_released", 0, outs(), 4'b0000);

        // Short load press (6 cycles): single load pulse after edge E0+6
        for (int i = 0; i < 15; i++) add(i < 6, 1'b0, 1'b0, (i == 6) ? 4'b1000 : 4'b0000);
        // Two-cycle up glitch: rejected
        for (int i = 0; i < 12; i++) add(1'b0, i < 2, 1'b0, 4'b0000);
        // Down glitch one sample short of DB_CYCLES: rejected
        for (int i = 0; i < 12; i++) add(1'b0, 1'b0, i < 3, 4'b0000);

        foreach (tbl[i]) begin
            cyc(tbl[i].bl, tbl[i].bu, tbl[i].bd, o);
            check("table", i, o, tbl[i].exp);
        end

        // Auto-repeat: up held 40 cycles
        for (int c = 0; c < 52; c++) begin
            cyc(1'b0, c < 40, 1'b0, o);
            exp_o = {1'b0, has(ups_auto, c), 1'b0, (c >= 14 && c <= 45)};
            check("autorepeat", c, o, exp_o);
        end

        // Conflict: down joins at 20, both released at 35, fresh down press at 45
        for (int c = 0; c < 66; c++) begin
            cyc(1'b0, c < 35, (c >= 20 && c < 35) || (c >= 45 && c < 51), o);
            exp_o = {1'b0, has(ups_conf, c), (c == 51), (c >= 14 && c <= 25)};
            check("conflict", c, o, exp_o);
        end

        // Load override while down is repeating
        for (int c = 0; c < 46; c++) begin
            cyc(c >= 20 && c < 30, 1'b0, c < 35, o);
            exp_o = {(c == 26), 1'b0, has(downs_ovr, c), (c >= 14 && c <= 25)};
            check("load_override", c, o, exp_o);
        end

        // Reset while up is repeating, up still held across release
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b1, 1'b0, o);
            exp_o = {1'b0, has(ups_rst, c), 1'b0, (c >= 14)};
            check("pre_reset", c, o, exp_o);
        end
        #2 reset = 1'b0;
        #1 check("reset_async", 0, outs(), 4'b0000);
        @(posedge clk);
        #1 check("reset_low", 1, outs(), 4'b0000);
        #2 reset = 1'b1;
        for (int c = 0; c < 36; c++) begin
            cyc(1'b0, c < 26, 1'b0, o);
            exp_o = {1'b0, has(ups_rst, c), 1'b0, (c >= 14 && c <= 31)};
            check("post_reset", c, o, exp_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
